// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the hardwired control sequencer: state codes, opcodes,
// datapath function/mux selects and the bundled control word.
package control_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_T0   = 3'd1,
    ST_T1   = 3'd2,
    ST_T2   = 3'd3,
    ST_T3   = 3'd4,
    ST_HALT = 3'd5
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_LSL  = 4'h6;
  localparam logic [3:0] OP_LSR  = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_BRA  = 4'hA;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_INC  = 4'hC;
  localparam logic [3:0] OP_DEC  = 4'hD;
  localparam logic [3:0] OP_MOV  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] ALU_PASS = 4'b0000;
  localparam logic [3:0] ALU_NOT  = 4'b0010;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0101;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_XOR  = 4'b1010;
  localparam logic [3:0] ALU_LSL  = 4'b1011;
  localparam logic [3:0] ALU_LSR  = 4'b1100;

  // Register-file and ARF share the same function encoding.
  localparam logic [1:0] FUN_CLR = 2'b00;
  localparam logic [1:0] FUN_LD  = 2'b01;
  localparam logic [1:0] FUN_DEC = 2'b10;
  localparam logic [1:0] FUN_INC = 2'b11;

  localparam logic [1:0] MUXA_ALU = 2'b00;
  localparam logic [1:0] MUXA_MEM = 2'b01;
  localparam logic [1:0] MUXA_IMM = 2'b10;
  localparam logic [1:0] MUXA_ARF = 2'b11;
  localparam logic [1:0] MUXB_ALU = 2'b00;
  localparam logic [1:0] MUXB_MEM = 2'b01;
  localparam logic [1:0] MUXB_IMM = 2'b10;

  localparam logic [1:0] ARF_AR = 2'd0;
  localparam logic [1:0] ARF_SP = 2'd1;
  localparam logic [1:0] ARF_PC = 2'd3;

  localparam logic [3:0] EN_IDLE   = 4'hF;
  localparam logic [3:0] EN_ARF_PC = 4'b1110;
  localparam logic [3:0] EN_ARF_AR = 4'b1101;
  localparam logic [3:0] EN_ARF_ALL = 4'b1000;

  typedef struct packed {
    logic       ir_lh;
    logic       ir_en;
    logic [1:0] ir_funsel;
    logic [2:0] rf_o1sel;
    logic [2:0] rf_o2sel;
    logic [1:0] rf_funsel;
    logic [3:0] rf_rsel;
    logic [3:0] rf_tsel;
    logic [1:0] arf_outasel;
    logic [1:0] arf_outbsel;
    logic [1:0] arf_funsel;
    logic [3:0] arf_regsel;
    logic [3:0] alu_funsel;
    logic [1:0] muxasel;
    logic [1:0] muxbsel;
    logic       mem_cs;
    logic       mem_wr;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    ir_lh: 1'b0, ir_en: 1'b0, ir_funsel: 2'b00,
    rf_o1sel: 3'd0, rf_o2sel: 3'd0, rf_funsel: FUN_CLR,
    rf_rsel: EN_IDLE, rf_tsel: EN_IDLE,
    arf_outasel: 2'd0, arf_outbsel: 2'd0, arf_funsel: FUN_CLR,
    arf_regsel: EN_IDLE, alu_funsel: ALU_PASS,
    muxasel: MUXA_ALU, muxbsel: MUXB_ALU,
    mem_cs: 1'b1, mem_wr: 1'b0
  };

  function automatic logic [3:0] alu_fun(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_NOT:  return ALU_NOT;
      OP_LSL:  return ALU_LSL;
      OP_LSR:  return ALU_LSR;
      default: return ALU_PASS;
    endcase
  endfunction

  // Active-low enable vector with only register idx enabled.
  function automatic logic [3:0] en_one(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // RegFile read select for R1..R4 (codes 4..7).
  function automatic logic [2:0] rf_sel(input logic [1:0] idx);
    return {1'b1, idx};
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bus between the sequencer (master) and the datapath (slave).
interface control_sequencer_if;
  logic [15:0] IRout;
  logic [3:0]  Flags;
  logic        IR_LH;
  logic        IR_En;
  logic [1:0]  IR_FunSel;
  logic [2:0]  RF_O1Sel;
  logic [2:0]  RF_O2Sel;
  logic [1:0]  RF_FunSel;
  logic [3:0]  RF_RSel;
  logic [3:0]  RF_TSel;
  logic [1:0]  ARF_OutASel;
  logic [1:0]  ARF_OutBSel;
  logic [1:0]  ARF_FunSel;
  logic [3:0]  ARF_RegSel;
  logic [3:0]  ALU_FunSel;
  logic [1:0]  MuxASel;
  logic [1:0]  MuxBSel;
  logic        Mem_CS;
  logic        Mem_WR;
  logic [2:0]  State;

  modport master (
    input  IRout, Flags,
    output IR_LH, IR_En, IR_FunSel, RF_O1Sel, RF_O2Sel, RF_FunSel, RF_RSel,
           RF_TSel, ARF_OutASel, ARF_OutBSel, ARF_FunSel, ARF_RegSel,
           ALU_FunSel, MuxASel, MuxBSel, Mem_CS, Mem_WR, State
  );

  modport slave (
    output IRout, Flags,
    input  IR_LH, IR_En, IR_FunSel, RF_O1Sel, RF_O2Sel, RF_FunSel, RF_RSel,
           RF_TSel, ARF_OutASel, ARF_OutBSel, ARF_FunSel, ARF_RegSel,
           ALU_FunSel, MuxASel, MuxBSel, Mem_CS, Mem_WR, State
  );
endinterface

// File: rtl/control_sequencer_decode.sv
// Purely combinational decode of (state, instruction, flags) into the
// datapath control word.
module sequencer_decode
  import control_sequencer_pkg::*;
(
  input  state_t      state,
  input  logic [15:0] ir,
  input  logic [3:0]  flags,
  output ctrl_t       ctrl
);

  logic [3:0] op;
  logic [1:0] dst;
  logic [1:0] src1;
  logic [1:0] src2;

  assign op   = ir[15:12];
  assign dst  = ir[11:10];
  assign src1 = ir[9:8];
  assign src2 = ir[7:6];

  // Immediate bits and the C/N/O flags feed the datapath directly, not here.
  logic unused_bits;
  assign unused_bits = ^{ir[5:0], flags[2:0]};

  // Control word per state; anything not set stays at its idle value.
  always_comb begin
    // NOTE: the full default first means every path assigns ctrl, so no latch.
    ctrl = CTRL_IDLE;
    case (state)
      ST_INIT: begin
        ctrl.rf_rsel    = 4'h0;
        ctrl.rf_tsel    = 4'h0;
        ctrl.arf_regsel = EN_ARF_ALL;
      end
      ST_T0, ST_T1: begin
        ctrl.ir_lh       = (state == ST_T1);
        ctrl.ir_en       = 1'b1;
        ctrl.ir_funsel   = FUN_LD;
        ctrl.arf_outbsel = ARF_PC;
        ctrl.mem_cs      = 1'b0;
        ctrl.arf_regsel  = EN_ARF_PC;
        ctrl.arf_funsel  = FUN_INC;
      end
      ST_T2: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LSL, OP_LSR,
          OP_MOV: begin
            ctrl.rf_o1sel   = rf_sel(src1);
            ctrl.rf_o2sel   = rf_sel(src2);
            ctrl.muxasel    = MUXA_ALU;
            ctrl.rf_funsel  = FUN_LD;
            ctrl.rf_rsel    = en_one(dst);
            ctrl.alu_funsel = alu_fun(op);
          end
          OP_LD, OP_ST: begin
            if (op == OP_LD && ir[9]) begin
              ctrl.muxasel   = MUXA_IMM;
              ctrl.rf_funsel = FUN_LD;
              ctrl.rf_rsel   = en_one(dst);
            end else begin
              ctrl.muxbsel    = MUXB_IMM;
              ctrl.arf_regsel = EN_ARF_AR;
              ctrl.arf_funsel = FUN_LD;
            end
          end
          OP_BRA, OP_BEQ: begin
            if (op == OP_BRA || flags[3]) begin
              ctrl.muxbsel    = MUXB_IMM;
              ctrl.arf_regsel = EN_ARF_PC;
              ctrl.arf_funsel = FUN_LD;
            end
          end
          OP_INC, OP_DEC: begin
            ctrl.rf_funsel = (op == OP_INC) ? FUN_INC : FUN_DEC;
            ctrl.rf_rsel   = en_one(dst);
          end
          default: ;
        endcase
      end
      ST_T3: begin
        if (op == OP_LD) begin
          ctrl.arf_outbsel = ARF_AR;
          ctrl.mem_cs      = 1'b0;
          ctrl.muxasel     = MUXA_MEM;
          ctrl.rf_funsel   = FUN_LD;
          ctrl.rf_rsel     = en_one(dst);
        end else if (op == OP_ST) begin
          ctrl.arf_outbsel = ARF_AR;
          ctrl.rf_o1sel    = rf_sel(dst);
          ctrl.alu_funsel  = ALU_PASS;
          ctrl.mem_cs      = 1'b0;
          ctrl.mem_wr      = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: state register, next-state logic and the
// decode sub-module driving the datapath control bus.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                CLK,
  input  logic                RST_N,
  control_sequencer_if.master bus
);

  localparam state_t RESET_STATE = INIT_CLEAR ? ST_INIT : ST_T0;

  state_t state;
  state_t state_next;
  ctrl_t  ctrl;

  // State register; reset lands in INIT (or T0) asynchronously.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= RESET_STATE;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state <= state_next;
    end
  end

  // Next state: fetch two bytes, then one or two execute cycles.
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT: state_next = ST_T0;
      ST_T0:   state_next = ST_T1;
      ST_T1:   state_next = ST_T2;
      ST_T2: begin
        case (bus.IRout[15:12])
          OP_HALT: state_next = ST_HALT;
          OP_LD:   state_next = bus.IRout[9] ? ST_T0 : ST_T3;
          OP_ST:   state_next = ST_T3;
          default: state_next = ST_T0;
        endcase
      end
      ST_T3:   state_next = ST_T0;
      ST_HALT: state_next = ST_HALT;
      default: state_next = RESET_STATE;
    endcase
  end

  sequencer_decode u_decode (
    .state (state),
    .ir    (bus.IRout),
    .flags (bus.Flags),
    .ctrl  (ctrl)
  );

  assign bus.IR_LH       = ctrl.ir_lh;
  assign bus.IR_En       = ctrl.ir_en;
  assign bus.IR_FunSel   = ctrl.ir_funsel;
  assign bus.RF_O1Sel    = ctrl.rf_o1sel;
  assign bus.RF_O2Sel    = ctrl.rf_o2sel;
  assign bus.RF_FunSel   = ctrl.rf_funsel;
  assign bus.RF_RSel     = ctrl.rf_rsel;
  assign bus.RF_TSel     = ctrl.rf_tsel;
  assign bus.ARF_OutASel = ctrl.arf_outasel;
  assign bus.ARF_OutBSel = ctrl.arf_outbsel;
  assign bus.ARF_FunSel  = ctrl.arf_funsel;
  assign bus.ARF_RegSel  = ctrl.arf_regsel;
  assign bus.ALU_FunSel  = ctrl.alu_funsel;
  assign bus.MuxASel     = ctrl.muxasel;
  assign bus.MuxBSel     = ctrl.muxbsel;
  assign bus.Mem_CS      = ctrl.mem_cs;
  assign bus.Mem_WR      = ctrl.mem_wr;
  assign bus.State       = state;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: each instruction is expanded by a per-instruction
// reference model into its expected cycle-by-cycle control words.
module tb_control_sequencer;

  typedef struct packed {
    logic [2:0] state;
    logic       ir_lh;
    logic       ir_en;
    logic [1:0] ir_fun;
    logic [2:0] o1;
    logic [2:0] o2;
    logic [1:0] rf_fun;
    logic [3:0] rsel;
    logic [3:0] tsel;
    logic [1:0] outa;
    logic [1:0] outb;
    logic [1:0] arf_fun;
    logic [3:0] regsel;
    logic [3:0] alu;
    logic [1:0] muxa;
    logic [1:0] muxb;
    logic       cs;
    logic       wr;
  } word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  word_t exp_q[$];

  control_sequencer_if bus ();
  control_sequencer_if bus0 ();

  control_sequencer #(.INIT_CLEAR(1'b1)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.master)
  );

  control_sequencer #(.INIT_CLEAR(1'b0)) dut_noclr (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus0.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic word_t observe();
    word_t w;
    w.state   = bus.State;
    w.ir_lh   = bus.IR_LH;
    w.ir_en   = bus.IR_En;
    w.ir_fun  = bus.IR_FunSel;
    w.o1      = bus.RF_O1Sel;
    w.o2      = bus.RF_O2Sel;
    w.rf_fun  = bus.RF_FunSel;
    w.rsel    = bus.RF_RSel;
    w.tsel    = bus.RF_TSel;
    w.outa    = bus.ARF_OutASel;
    w.outb    = bus.ARF_OutBSel;
    w.arf_fun = bus.ARF_FunSel;
    w.regsel  = bus.ARF_RegSel;
    w.alu     = bus.ALU_FunSel;
    w.muxa    = bus.MuxASel;
    w.muxb    = bus.MuxBSel;
    w.cs      = bus.Mem_CS;
    w.wr      = bus.Mem_WR;
    return w;
  endfunction

  function automatic word_t idle(input logic [2:0] st);
    word_t w = '0;
    w.state  = st;
    w.rsel   = 4'hF;
    w.tsel   = 4'hF;
    w.regsel = 4'hF;
    w.cs     = 1'b1;
    return w;
  endfunction

  function automatic word_t init_word();
    word_t w = idle(3'd0);
    w.rsel   = 4'h0;
    w.tsel   = 4'h0;
    w.regsel = 4'b1000;
    return w;
  endfunction

  function automatic logic [3:0] alu_code(input logic [3:0] op);
    logic [3:0] tab [0:15];
    tab = '{4'b0100, 4'b0101, 4'b0111, 4'b1000, 4'b1010, 4'b0010, 4'b1011, 4'b1100,
            4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 4'h0};
    return tab[op];
  endfunction

  // Expected cycles of one instruction, starting in T0.
  task automatic build_expected(input logic [15:0] ir, input logic [3:0] fl);
    logic [3:0] op  = ir[15:12];
    logic [1:0] dst = ir[11:10];
    logic [3:0] dst_en = 4'hF ^ (4'd1 << dst);
    word_t w;
    w = idle(3'd1);
    w.outb = 2'd3; w.cs = 1'b0; w.ir_en = 1'b1; w.ir_fun = 2'b01;
    w.regsel = 4'b1110; w.arf_fun = 2'b11;
    exp_q.push_back(w);
    w.state = 3'd2; w.ir_lh = 1'b1;
    exp_q.push_back(w);
    w = idle(3'd3);
    if (op <= 4'h7 || op == 4'hE) begin
      w.o1 = 3'(4 + int'(ir[9:8]));
      w.o2 = 3'(4 + int'(ir[7:6]));
      w.rf_fun = 2'b01; w.rsel = dst_en; w.alu = alu_code(op);
      exp_q.push_back(w);
    end else if (op == 4'h8 && ir[9]) begin
      w.muxa = 2'b10; w.rf_fun = 2'b01; w.rsel = dst_en;
      exp_q.push_back(w);
    end else if (op == 4'h8 || op == 4'h9) begin
      w.muxb = 2'b10; w.regsel = 4'b1101; w.arf_fun = 2'b01;
      exp_q.push_back(w);
      w = idle(3'd4);
      w.outb = 2'd0; w.cs = 1'b0;
      if (op == 4'h8) begin
        w.muxa = 2'b01; w.rf_fun = 2'b01; w.rsel = dst_en;
      end else begin
        w.o1 = 3'(4 + int'(dst)); w.alu = 4'b0000; w.wr = 1'b1;
      end
      exp_q.push_back(w);
    end else if (op == 4'hA || (op == 4'hB && fl[3])) begin
      w.muxb = 2'b10; w.regsel = 4'b1110; w.arf_fun = 2'b01;
      exp_q.push_back(w);
    end else if (op == 4'hC || op == 4'hD) begin
      w.rf_fun = (op == 4'hC) ? 2'b11 : 2'b10; w.rsel = dst_en;
      exp_q.push_back(w);
    end else begin
      exp_q.push_back(w);
    end
  endtask

  // Entered just after the edge into T0; leaves just after the edge into the next T0.
  task automatic run_instr(input string tag, input logic [15:0] ir, input logic [3:0] fl);
    int cyc = 0;
    bus.IRout = ir;
    bus.Flags = fl;
    build_expected(ir, fl);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      check($sformatf("%s_%h_c%0d", tag, ir, cyc), 64'(observe()), 64'(exp_q.pop_front()));
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [15:0] ir;
    logic [3:0]  fl;
    bus.IRout = '0;  bus.Flags = '0;
    bus0.IRout = '0; bus0.Flags = '0;

    repeat (2) @(negedge clk);
    check("reset_init_word", 64'(observe()), 64'(init_word()));
    check("noclr_reset_state", 64'(bus0.State), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("noclr_first_fetch", 64'(bus0.State), 64'd2);

    run_instr("or_r1", 16'h36C0, 4'h0);
    run_instr("add_r1", 16'h06C0, 4'h0);
    run_instr("ld_direct", 16'h8042, 4'h0);
    run_instr("ld_imm", 16'h8E55, 4'h0);
    run_instr("beq_taken", 16'hB010, 4'b1000);
    run_instr("beq_not", 16'hB010, 4'b0000);
    run_instr("bra", 16'hA0FF, 4'h0);

    repeat (150) begin
      ir = 16'($urandom);
      if (ir[15:12] == 4'hF) ir[15:12] = 4'($urandom_range(0, 14));
      fl = 4'($urandom);
      run_instr("rand", ir, fl);
    end

    // Store, then reset during its write cycle.
    bus.IRout = 16'h9810;
    bus.Flags = 4'h0;
    build_expected(16'h9810, 4'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("st_c%0d", c), 64'(observe()), 64'(exp_q.pop_front()));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("st_write_cycle", 64'(observe()), 64'(exp_q.pop_front()));
    #2 rst_n = 1'b0;
    #1;
    check("st_abort_word", 64'(observe()), 64'(init_word()));
    check("st_abort_cs", 64'(bus.Mem_CS), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_instr("after_abort", 16'hC400, 4'h0);

    run_instr("halt", 16'hF000, 4'h0);
    for (int c = 0; c < 12; c++) begin
      bus.IRout = 16'($urandom);
      bus.Flags = 4'($urandom);
      @(negedge clk);
      check($sformatf("halt_hold_%0d", c), 64'(observe()), 64'(idle(3'd5)));
      @(posedge clk); #1;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("halt_reset", 64'(observe()), 64'(init_word()));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_instr("after_halt", 16'h1B40, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
